// File: rtl/joy_drv_if.sv
// CPU-side bus bundle for the NES controller emulator.
// Master is the CPU/bus model, slave is joy_drv.
interface joy_drv_if;
  logic        cpu_m2;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_di;
  logic        joy_d0;
  logic        joy_oe;

  modport master (
    output cpu_m2, cpu_addr, cpu_rw, cpu_di,
    input  joy_d0, joy_oe
  );

  modport slave (
    input  cpu_m2, cpu_addr, cpu_rw, cpu_di,
    output joy_d0, joy_oe
  );
endinterface

// File: rtl/joy_drv.sv
// Two-port NES controller emulator answering $4016/$4017 reads
// from PI-supplied button bytes; everything runs on clk.
module joy_drv #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        AFTER_BIT   = 1'b1,
  parameter logic [1:0]  PORT_EN     = 2'b11
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  joy_drv_if.slave   bus,
  input  logic       drv_en,
  input  logic [7:0] btn0,
  input  logic [7:0] btn1,
  output logic       strobe,
  output logic [7:0] poll_cnt,
  output logic [3:0] rd_cnt0,
  output logic [3:0] rd_cnt1
);

  localparam logic [0:0] ST_SHIFT = 1'b0;
  localparam logic [0:0] ST_LOAD  = 1'b1;
  localparam logic [15:0] A_P0 = 16'h4016;
  localparam logic [15:0] A_P1 = 16'h4017;

  logic [SYNC_STAGES-1:0] sync_q, settle_q;
  logic        m2s_d_q, armed_q, armed_d, cyc_v_q, cyc_v_d;
  logic [15:0] addr_q;
  logic        rw_q, di0_q;
  logic [0:0]  state_q, state_d;
  logic [7:0]  poll_q, poll_d;
  logic [7:0]  sh0_q, sh0_d, sh1_q, sh1_d;
  logic [3:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        oe_q, oe_d, d0_q, d0_d;

  logic m2s, settled, m2_rise, m2_fall;
  logic wr_p0, rd_p0, rd_p1;
  logic hit0, hit1, bit0, bit1, live;

  assign m2s     = sync_q[SYNC_STAGES-1];
  assign settled = settle_q[SYNC_STAGES-1];
  // A cycle already in progress when reset lifts is never acted on.
  assign armed_d = armed_q | (settled & ~m2s);
  assign m2_rise = m2s & ~m2s_d_q & armed_q;
  assign m2_fall = ~m2s & m2s_d_q & cyc_v_q;

  always_comb begin
    cyc_v_d = cyc_v_q;
    if (m2_rise) cyc_v_d = 1'b1;
    else if (m2_fall) cyc_v_d = 1'b0;
  end

  assign wr_p0 = m2_fall & ~rw_q & (addr_q == A_P0);
  assign rd_p0 = m2_fall & rw_q & (addr_q == A_P0);
  assign rd_p1 = m2_fall & rw_q & (addr_q == A_P1);

  always_comb begin
    state_d = state_q;
    poll_d  = poll_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (state_q == ST_LOAD) begin
      sh0_d  = btn0;
      sh1_d  = btn1;
      cnt0_d = 4'd0;
      cnt1_d = 4'd0;
    end else begin
      if (rd_p0) begin
        sh0_d  = {sh0_q[6:0], AFTER_BIT};
        cnt0_d = (cnt0_q == 4'd8) ? 4'd8 : cnt0_q + 4'd1;
      end
      if (rd_p1) begin
        sh1_d  = {sh1_q[6:0], AFTER_BIT};
        cnt1_d = (cnt1_q == 4'd8) ? 4'd8 : cnt1_q + 4'd1;
      end
    end
    if (wr_p0) begin
      state_d = di0_q;
      if (state_q == ST_LOAD && !di0_q) poll_d = poll_q + 8'd1;
    end
  end

  assign hit0 = bus.cpu_rw & (bus.cpu_addr == A_P0) & PORT_EN[0];
  assign hit1 = bus.cpu_rw & (bus.cpu_addr == A_P1) & PORT_EN[1];
  assign live = cyc_v_q | m2_rise;

  always_comb begin
    bit0 = (cnt0_q < 4'd8) ? sh0_q[7] : AFTER_BIT;
    bit1 = (cnt1_q < 4'd8) ? sh1_q[7] : AFTER_BIT;
    // While latching, A is passed straight through.
    if (state_q == ST_LOAD) begin
      bit0 = btn0[7];
      bit1 = btn1[7];
    end
    oe_d = drv_en & m2s & live & (hit0 | hit1);
    d0_d = oe_d & (hit0 ? bit0 : bit1);
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= '0;
      settle_q <= '0;
      m2s_d_q  <= 1'b0;
      armed_q  <= 1'b0;
      cyc_v_q  <= 1'b0;
      addr_q   <= 16'h0;
      rw_q     <= 1'b0;
      di0_q    <= 1'b0;
      state_q  <= ST_SHIFT;
      poll_q   <= 8'h00;
      sh0_q    <= 8'hFF;
      sh1_q    <= 8'hFF;
      cnt0_q   <= 4'd0;
      cnt1_q   <= 4'd0;
      oe_q     <= 1'b0;
      d0_q     <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.cpu_m2};
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      m2s_d_q  <= m2s;
      armed_q  <= armed_d;
      cyc_v_q  <= cyc_v_d;
      if (m2_rise) begin
        addr_q <= bus.cpu_addr;
        rw_q   <= bus.cpu_rw;
        di0_q  <= bus.cpu_di[0];
      end
      state_q <= state_d;
      poll_q  <= poll_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      oe_q    <= oe_d;
      d0_q    <= d0_d;
    end
  end

  assign bus.joy_oe = oe_q;
  assign bus.joy_d0 = d0_q;
  assign strobe     = state_q;
  assign poll_cnt   = poll_q;
  assign rd_cnt0    = cnt0_q;
  assign rd_cnt1    = cnt1_q;

endmodule

// File: tb/tb_joy_drv.sv
// Scoreboard bench for joy_drv: reads queue expected D0, a monitor
// pops on each joy_oe assertion; counters are checked directly.
module tb_joy_drv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m2 = 1'b0;
  logic [15:0] addr = 16'h0;
  logic        rw = 1'b1;
  logic [7:0]  di = 8'h00;
  logic        drv_en = 1'b1;
  logic [7:0]  btn0 = 8'h00;
  logic [7:0]  btn1 = 8'h00;

  logic       strobe_a, strobe_b;
  logic [7:0] poll_a, poll_b;
  logic [3:0] rc0_a, rc1_a, rc0_b, rc1_b;

  int n_chk = 0;
  int n_fail = 0;
  logic exp_q[$];
  logic oe_prev = 1'b0;
  logic oe_b_p1 = 1'b0;

  joy_drv_if bus_a ();
  joy_drv_if bus_b ();

  assign bus_a.cpu_m2   = m2;
  assign bus_a.cpu_addr = addr;
  assign bus_a.cpu_rw   = rw;
  assign bus_a.cpu_di   = di;
  assign bus_b.cpu_m2   = m2;
  assign bus_b.cpu_addr = addr;
  assign bus_b.cpu_rw   = rw;
  assign bus_b.cpu_di   = di;

  joy_drv u_a (
    .clk(clk), .sys_rst_n(rst_n), .bus(bus_a), .drv_en(drv_en),
    .btn0(btn0), .btn1(btn1), .strobe(strobe_a), .poll_cnt(poll_a),
    .rd_cnt0(rc0_a), .rd_cnt1(rc1_a)
  );

  joy_drv #(.PORT_EN(2'b01)) u_b (
    .clk(clk), .sys_rst_n(rst_n), .bus(bus_b), .drv_en(drv_en),
    .btn0(btn0), .btn1(btn1), .strobe(strobe_b), .poll_cnt(poll_b),
    .rd_cnt0(rc0_b), .rd_cnt1(rc1_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: one expected D0 per joy_oe assertion.
  always @(negedge clk) begin
    if (bus_a.joy_oe && !oe_prev) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_oe: got oe=1 expected no drive (addr %0h)",
                 addr);
      end else begin
        chk("d0", {7'd0, bus_a.joy_d0}, {7'd0, exp_q.pop_front()});
      end
    end
    oe_prev = bus_a.joy_oe;
    if (bus_b.joy_oe && addr == 16'h4017) oe_b_p1 = 1'b1;
  end

  task automatic cyc(input logic [15:0] a, input logic r,
                     input logic [7:0] d);
    addr = a;
    rw = r;
    di = d;
    #20;
    m2 = 1'b1;
    #120;
    m2 = 1'b0;
    #120;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(16'h4016, 1'b0, d);
  endtask

  task automatic rd(input logic [15:0] a, input logic e);
    exp_q.push_back(e);
    cyc(a, 1'b1, 8'h00);
  endtask

  logic [7:0] seq1;
  logic [7:0] seq3;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #37;
    rst_n = 1'b1;
    #40;
    chk("rst_oe", {7'd0, bus_a.joy_oe}, 8'd0);
    chk("rst_d0", {7'd0, bus_a.joy_d0}, 8'd0);
    chk("rst_strobe", {7'd0, strobe_a}, 8'd0);
    chk("rst_poll", poll_a, 8'd0);
    chk("rst_rc0", {4'd0, rc0_a}, 8'd0);
    chk("rst_rc1", {4'd0, rc1_a}, 8'd0);

    // 1: latch 0x90, A..Right then after-bits
    btn0 = 8'h90;
    wr(8'h01);
    wr(8'h00);
    seq1 = 8'b1001_0000;
    for (int i = 7; i >= 0; i--) rd(16'h4016, seq1[i]);
    rd(16'h4016, 1'b1);
    rd(16'h4016, 1'b1);
    chk("t1_rc0", {4'd0, rc0_a}, 8'd8);
    chk("t1_poll", poll_a, 8'd1);
    chk("t1_rc1", {4'd0, rc1_a}, 8'd0);

    // 2: strobe high, A is live
    wr(8'h01);
    btn0 = 8'h80;
    rd(16'h4016, 1'b1);
    btn0 = 8'h00;
    rd(16'h4016, 1'b0);
    btn0 = 8'h80;
    rd(16'h4016, 1'b1);
    chk("t2_rc0", {4'd0, rc0_a}, 8'd0);
    chk("t2_strobe", {7'd0, strobe_a}, 8'd1);
    chk("t2_poll", poll_a, 8'd1);

    // 3: port 2 latch, later btn change is invisible
    btn1 = 8'h01;
    wr(8'h00);
    btn1 = 8'hFF;
    seq3 = 8'b0000_0001;
    for (int i = 7; i >= 0; i--) rd(16'h4017, seq3[i]);
    chk("t3_rc1", {4'd0, rc1_a}, 8'd8);
    chk("t3_rc0", {4'd0, rc0_a}, 8'd0);
    chk("t3_poll", poll_a, 8'd2);

    // 4: passive reads still shift
    btn0 = 8'h10;
    drv_en = 1'b0;
    wr(8'h01);
    wr(8'h00);
    for (int i = 0; i < 3; i++) cyc(16'h4016, 1'b1, 8'h00);
    chk("t4_rc0_passive", {4'd0, rc0_a}, 8'd3);
    drv_en = 1'b1;
    rd(16'h4016, 1'b1);
    chk("t4_rc0", {4'd0, rc0_a}, 8'd4);
    chk("t4_poll", poll_a, 8'd3);

    // 5: disabled port 2 on u_b; $4017 write ignored
    rd(16'h4017, 1'b1);
    cyc(16'h4017, 1'b0, 8'h01);
    chk("t5_b_oe_4017", {7'd0, oe_b_p1}, 8'd0);
    chk("t5_b_strobe", {7'd0, strobe_b}, 8'd0);
    chk("t5_b_poll", poll_b, 8'd3);
    chk("t5_a_strobe", {7'd0, strobe_a}, 8'd0);
    chk("t5_b_rc1", {4'd0, rc1_b}, 8'd1);

    // 6: reset in the middle of a read
    exp_q.push_back(1'b0);
    addr = 16'h4016;
    rw = 1'b1;
    #20;
    m2 = 1'b1;
    begin
      int k;
      k = 0;
      while (!bus_a.joy_oe && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk("t6_oe_seen", {7'd0, bus_a.joy_oe}, 8'd1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_oe", {7'd0, bus_a.joy_oe}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #60;
    m2 = 1'b0;
    #120;
    chk("t6_strobe", {7'd0, strobe_a}, 8'd0);
    chk("t6_poll", poll_a, 8'd0);
    chk("t6_rc0_noshift", {4'd0, rc0_a}, 8'd0);
    rd(16'h4016, 1'b1);
    chk("t6_rc0", {4'd0, rc0_a}, 8'd1);

    #50;
    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
